// File: rtl/fsm_ex3_pkg.sv
// Shared encodings and combinational helpers for the example3 Moore FSM and its path driver.
package fsm_ex3_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [ST_W-1:0] S0 = 3'd0;
  localparam logic [ST_W-1:0] S1 = 3'd1;
  localparam logic [ST_W-1:0] S2 = 3'd2;
  localparam logic [ST_W-1:0] S3 = 3'd3;
  localparam logic [ST_W-1:0] S5 = 3'd4;
  localparam logic [ST_W-1:0] S6 = 3'd5;

  typedef enum logic {
    CTL_IDLE = 1'b0,
    CTL_BUSY = 1'b1
  } ctl_state_e;

  function automatic logic [ST_W-1:0] fsm_ex3_next(input logic [ST_W-1:0] state, input logic x);
    logic [ST_W-1:0] nxt;
    case (state)
      S0:      nxt = x ? S2 : S1;
      S1:      nxt = x ? S5 : S3;
      S2:      nxt = x ? S2 : S5;
      S3:      nxt = x ? S6 : S1;
      S5:      nxt = x ? S3 : S2;
      S6:      nxt = x ? S6 : S5;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  function automatic logic fsm_ex3_out(input logic [ST_W-1:0] state);
    return (state == S0) || (state == S1) || (state == S3);
  endfunction

  // First bit of the shortest path; ties resolve to x=0, S2/S6 always hop with 0.
  function automatic logic fsm_ex3_hop(input logic [ST_W-1:0] cur, input logic [ST_W-1:0] tgt);
    logic hop;
    case (cur)
      S0:      hop = (tgt == S2);
      S1:      hop = (tgt == S5) || (tgt == S2);
      S3:      hop = (tgt == S6);
      S5:      hop = (tgt == S1) || (tgt == S3) || (tgt == S6);
      default: hop = 1'b0;
    endcase
    return hop;
  endfunction

endpackage

// File: rtl/fsm_ex3_shadow.sv
// Cycle-accurate shadow of the example3 FSM: state register plus Moore output.
module fsm_ex3_shadow
  import fsm_ex3_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_x,
  output logic [ST_W-1:0] o_state,
  output logic            o_moore_c
);

  logic [ST_W-1:0] r_state;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S0;
    else            r_state <= fsm_ex3_next(r_state, i_x);
  end

  assign o_state   = r_state;
  assign o_moore_c = fsm_ex3_out(r_state);

endmodule

// File: rtl/fsm_path_driver.sv
// Steers the example3 FSM to a requested state via its serial input and flags arrival.
// Optional output checker enabled by defining FSM_PATH_CHECK_EN.
module fsm_path_driver
  import fsm_ex3_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 4,
  parameter logic        IDLE_X    = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ST_W-1:0] req_state,
  output logic            x,
  output logic [ST_W-1:0] cur_state,
  output logic            done,
  output logic            err,
  input  logic            obs_out,
  output logic            mismatch
);

  ctl_state_e       r_ctl, w_ctl_nxt;
  logic [ST_W-1:0]  r_tgt, w_tgt_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic [ST_W-1:0]  w_shadow;
  logic             w_moore;
  logic             w_x, w_ready, w_done;

  fsm_ex3_shadow u_shadow (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_x       (w_x),
    .o_state   (w_shadow),
    .o_moore_c (w_moore)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctl <= CTL_IDLE;
      r_tgt <= S0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_ctl <= w_ctl_nxt;
      r_tgt <= w_tgt_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_ctl_nxt = r_ctl;
    w_tgt_nxt = r_tgt;
    w_cnt_nxt = r_cnt;
    w_err_nxt = 1'b0;
    w_x       = IDLE_X;
    w_ready   = 1'b0;
    w_done    = 1'b0;
    case (r_ctl)
      CTL_IDLE: begin
        w_ready = 1'b1;
        if (req_valid) begin
          w_tgt_nxt = req_state;
          // S0 only reachable through reset; codes above S6 are not states
          if ((req_state == S0) || (req_state > S6)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_ctl_nxt = CTL_BUSY;
            w_cnt_nxt = '0;
          end
        end
      end
      CTL_BUSY: begin
        if (w_shadow == r_tgt) begin
          w_done    = 1'b1;
          w_ctl_nxt = CTL_IDLE;
        end else if (r_cnt >= CNT_W'(MAX_STEPS)) begin
          w_err_nxt = 1'b1;
          w_ctl_nxt = CTL_IDLE;
        end else begin
          w_x       = fsm_ex3_hop(w_shadow, r_tgt);
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_ctl_nxt = CTL_IDLE;
    endcase
    // Outputs look idle while reset is held, whatever the registers hold
    if (!reset_n) begin
      w_x     = IDLE_X;
      w_ready = 1'b1;
      w_done  = 1'b0;
    end
  end

  assign x         = w_x;
  assign req_ready = w_ready;
  assign done      = w_done;
  assign err       = r_err;
  assign cur_state = w_shadow;

`ifdef FSM_PATH_CHECK_EN
  logic r_mismatch;

  always_ff @(posedge clk) begin
    if (!reset_n)                r_mismatch <= 1'b0;
    else if (obs_out != w_moore) r_mismatch <= 1'b1;
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused_obs;
  assign w_unused_obs = obs_out ^ w_moore;
  assign mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_path_driver.sv
// Directed self-checking bench for fsm_path_driver; expected vectors are hand-derived.
module tb_fsm_path_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_state = 3'd0;
  logic       obs_out;
  logic       req_ready, x, done, err, mismatch;
  logic [2:0] cur_state;
  logic       force_obs0 = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

`ifdef FSM_PATH_CHECK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  fsm_path_driver #(.MAX_STEPS(4), .IDLE_X(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_state (req_state),
    .x         (x),
    .cur_state (cur_state),
    .done      (done),
    .err       (err),
    .obs_out   (obs_out),
    .mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  // Ideal example3 output for the observed state, optionally forced wrong
  function automatic logic moore(input logic [2:0] s);
    return (s == 3'd0) || (s == 3'd1) || (s == 3'd3);
  endfunction
  always_comb obs_out = force_obs0 ? 1'b0 : moore(cur_state);

  // Leaves the bench at the first cycle after reset, inputs idle
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b0; req_state = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Vector layout: {cur_state, x, req_ready, done, err}
  task automatic test_reset();
    logic [6:0] exp_v, got;
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      got = {3'd0, x, req_ready, done, 1'b0};
      exp_v = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_held[%0d]: got %b expected %b", i, got, exp_v);
      end
      n_checks++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      got = {cur_state, x, req_ready, done, err};
      exp_v = {(i == 0) ? 3'd0 : 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL idle_walk[%0d]: got %b expected %b", i, got, exp_v);
      end
      n_checks++;
      if (mismatch !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_mismatch[%0d]: got %b expected 0", i, mismatch);
      end
      n_checks++;
    end
  endtask

  // Steer to S3 from reset, then back-to-back request for S5 right after done
  task automatic test_steer_back_to_back();
    logic [6:0] exp_v [8];
    logic [3:0] stim  [8];
    logic [6:0] got;
    exp_v = '{ {3'd0,1'b1,1'b1,1'b0,1'b0}, {3'd2,1'b0,1'b0,1'b0,1'b0},
               {3'd4,1'b1,1'b0,1'b0,1'b0}, {3'd3,1'b1,1'b0,1'b1,1'b0},
               {3'd5,1'b1,1'b1,1'b0,1'b0}, {3'd5,1'b0,1'b0,1'b0,1'b0},
               {3'd4,1'b1,1'b0,1'b1,1'b0}, {3'd3,1'b1,1'b1,1'b0,1'b0} };
    stim  = '{ {1'b1,3'd3}, 4'd0, 4'd0, 4'd0, {1'b1,3'd4}, 4'd0, 4'd0, 4'd0 };
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      {req_valid, req_state} = stim[i];
      #1;
      got = {cur_state, x, req_ready, done, err};
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL steer[%0d]: got %b expected %b", i, got, exp_v[i]);
      end
      n_checks++;
    end
  endtask

  // Target equal to post-accept shadow: done immediately, no steering
  task automatic test_same_state();
    logic [6:0] exp_v [4];
    logic [3:0] stim  [4];
    logic [6:0] got;
    exp_v = '{ {3'd0,1'b1,1'b1,1'b0,1'b0}, {3'd2,1'b1,1'b1,1'b0,1'b0},
               {3'd2,1'b1,1'b0,1'b1,1'b0}, {3'd2,1'b1,1'b1,1'b0,1'b0} };
    stim  = '{ 4'd0, {1'b1,3'd2}, 4'd0, 4'd0 };
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      {req_valid, req_state} = stim[i];
      #1;
      got = {cur_state, x, req_ready, done, err};
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL same_state[%0d]: got %b expected %b", i, got, exp_v[i]);
      end
      n_checks++;
    end
  endtask

  // Requests for S0, 6 and 7 are rejected with a one-cycle err
  task automatic test_reject();
    logic [6:0] exp_v [7];
    logic [3:0] stim  [7];
    logic [6:0] got;
    exp_v = '{ {3'd0,1'b1,1'b1,1'b0,1'b0}, {3'd2,1'b1,1'b1,1'b0,1'b1},
               {3'd2,1'b1,1'b1,1'b0,1'b0}, {3'd2,1'b1,1'b1,1'b0,1'b1},
               {3'd2,1'b1,1'b1,1'b0,1'b0}, {3'd2,1'b1,1'b1,1'b0,1'b1},
               {3'd2,1'b1,1'b1,1'b0,1'b0} };
    stim  = '{ {1'b1,3'd0}, 4'd0, {1'b1,3'd6}, 4'd0, {1'b1,3'd7}, 4'd0, 4'd0 };
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      {req_valid, req_state} = stim[i];
      #1;
      got = {cur_state, x, req_ready, done, err};
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL reject[%0d]: got %b expected %b", i, got, exp_v[i]);
      end
      n_checks++;
    end
  endtask

  // Steering to S1 from S2 abandoned by reset two cycles after accept
  task automatic test_reset_mid_busy();
    logic [6:0] exp_v [6];
    logic [4:0] stim  [6];
    logic [6:0] got;
    exp_v = '{ {3'd0,1'b1,1'b1,1'b0,1'b0}, {3'd2,1'b1,1'b1,1'b0,1'b0},
               {3'd2,1'b0,1'b0,1'b0,1'b0}, {3'd4,1'b1,1'b1,1'b0,1'b0},
               {3'd0,1'b1,1'b1,1'b0,1'b0}, {3'd2,1'b1,1'b1,1'b0,1'b0} };
    stim  = '{ {1'b1,4'd0}, {1'b1,1'b1,3'd1}, {1'b1,4'd0},
               {1'b0,4'd0}, {1'b1,4'd0}, {1'b1,4'd0} };
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      {reset_n, req_valid, req_state} = stim[i];
      #1;
      got = {cur_state, x, req_ready, done, err};
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL reset_mid_busy[%0d]: got %b expected %b", i, got, exp_v[i]);
      end
      n_checks++;
    end
  endtask

  // Wrong obs_out in S0 sets a sticky flag (checker build) or is ignored
  task automatic test_mismatch();
    do_reset();
    #1;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_after_reset: got %b expected 0", mismatch);
    end
    n_checks++;
    force_obs0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      force_obs0 = 1'b0;
      #1;
      if (mismatch !== CHK_ON) begin
        n_fail++;
        $display("FAIL mismatch_sticky[%0d]: got %b expected %b", i, mismatch, CHK_ON);
      end
      n_checks++;
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (mismatch !== 1'b0) begin
        n_fail++;
        $display("FAIL mismatch_cleared[%0d]: got %b expected 0", i, mismatch);
      end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_steer_back_to_back();
    test_same_state();
    test_reject();
    test_reset_mid_busy();
    test_mismatch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
